// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared types and constants for the oven heater controller
// Purpose: FSM state encoding, heat-level constants, legal target range and
//          a clamp helper shared by oven_heat_ctrl and oven_heat_law.
// Ports:   none (package).
package oven_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREHEAT = 3'd1,
    ST_BAKE    = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [1:0] HEAT_OFF  = 2'd0;
  localparam logic [1:0] HEAT_LOW  = 2'd1;
  localparam logic [1:0] HEAT_MID  = 2'd2;
  localparam logic [1:0] HEAT_HIGH = 2'd3;

  localparam int T_MIN = 65;
  localparam int T_MAX = 511;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/oven_heat_ctrl_if.sv
// rtl/oven_heat_ctrl_if.sv - request/feedback/status bundle of the heater controller
// Purpose: groups every non-clock, non-reset signal of oven_heat_ctrl.
// Ports (master view): drives start, cancel, target_temp, bake_cycles,
//          current_temp, preheated; observes target_q, heat, state, ready,
//          done, remaining. The slave modport is the controller side.
interface oven_heat_ctrl_if #(
  parameter int TEMP_W = 10,
  parameter int TIME_W = 16
);

  logic              start;
  logic              cancel;
  logic [TEMP_W-1:0] target_temp;
  logic [TIME_W-1:0] bake_cycles;
  logic [TEMP_W-1:0] current_temp;
  logic              preheated;
  logic [TEMP_W-1:0] target_q;
  logic [1:0]        heat;
  logic [2:0]        state;
  logic              ready;
  logic              done;
  logic [TIME_W-1:0] remaining;

  modport master (
    output start, cancel, target_temp, bake_cycles, current_temp, preheated,
    input  target_q, heat, state, ready, done, remaining
  );

  modport slave (
    input  start, cancel, target_temp, bake_cycles, current_temp, preheated,
    output target_q, heat, state, ready, done, remaining
  );

endinterface

// File: rtl/oven_heat_law.sv
// rtl/oven_heat_law.sv - combinational temperature-error to heat-level mapper
// Purpose: heat = 3/2/1/0 for err = target - current above BAND_HI, above
//          BAND_MID, above 0, or not positive.
// Ports:   target (in, TEMP_W), current (in, TEMP_W), heat (out, 2).
module oven_heat_law
  import oven_pkg::*;
#(
  parameter int TEMP_W   = 10,
  parameter int BAND_HI  = 40,
  parameter int BAND_MID = 10
) (
  input  logic [TEMP_W-1:0] target,
  input  logic [TEMP_W-1:0] current,
  output logic [1:0]        heat
);

  localparam logic signed [TEMP_W:0] BAND_HI_S  = (TEMP_W+1)'(BAND_HI);
  localparam logic signed [TEMP_W:0] BAND_MID_S = (TEMP_W+1)'(BAND_MID);

  // One extra bit so a target below the current temperature goes negative.
  logic signed [TEMP_W:0] err;

  assign err = $signed({1'b0, target}) - $signed({1'b0, current});

  always_comb begin
    heat = HEAT_OFF;
    if (err > BAND_HI_S) begin
      heat = HEAT_HIGH;
    end else if (err > BAND_MID_S) begin
      heat = HEAT_MID;
    end else if (err > 0) begin
      heat = HEAT_LOW;
    end
  end

endmodule

// File: rtl/oven_heat_ctrl.sv
// rtl/oven_heat_ctrl.sv - bake-request heater controller in front of the oven model
// Purpose: latches a bake request, regulates heat from the latched target and
//          fed-back temperature, waits for preheat, counts the bake and pulses
//          done. Optional macro OVEN_PREHEAT_TIMEOUT_EN adds a preheat timeout
//          that parks the controller in FAULT until cancel or reset.
// Ports:   clk (in), reset (in, async active-high),
//          bus (oven_heat_ctrl_if.slave): start, cancel, target_temp,
//          bake_cycles, current_temp, preheated in; target_q, heat, state,
//          ready, done, remaining out.
module oven_heat_ctrl #(
  parameter int TEMP_W          = 10,
  parameter int TIME_W          = 16,
  parameter int BAND_HI         = 40,
`ifdef OVEN_PREHEAT_TIMEOUT_EN
  parameter int PREHEAT_TIMEOUT = 4096,
`endif
  parameter int BAND_MID        = 10
) (
  input  logic            clk,
  input  logic            reset,
  oven_heat_ctrl_if.slave bus
);

  import oven_pkg::*;

  state_t            state_q, state_d;
  logic [TEMP_W-1:0] target_q, target_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [1:0]        heat_q, heat_d;
  logic              done_q, done_d;
  logic [1:0]        law_heat;

`ifdef OVEN_PREHEAT_TIMEOUT_EN
  localparam int PC_W = (PREHEAT_TIMEOUT > 2) ? $clog2(PREHEAT_TIMEOUT) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PREHEAT_TIMEOUT - 1);
  logic [PC_W-1:0] pc_q, pc_d;
`endif

  // Regulate against the target that will be held next cycle, so the first
  // PREHEAT cycle already heats toward the freshly latched target.
  oven_heat_law #(
    .TEMP_W  (TEMP_W),
    .BAND_HI (BAND_HI),
    .BAND_MID(BAND_MID)
  ) u_law (
    .target (target_d),
    .current(bus.current_temp),
    .heat   (law_heat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= TEMP_W'(T_MIN);
      rem_q    <= '0;
      heat_q   <= HEAT_OFF;
      done_q   <= 1'b0;
`ifdef OVEN_PREHEAT_TIMEOUT_EN
      pc_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rem_q    <= rem_d;
      heat_q   <= heat_d;
      done_q   <= done_d;
`ifdef OVEN_PREHEAT_TIMEOUT_EN
      pc_q     <= pc_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
`ifdef OVEN_PREHEAT_TIMEOUT_EN
    pc_d     = pc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // cancel beats a simultaneous start
        if (bus.start && !bus.cancel) begin
          state_d  = ST_PREHEAT;
          target_d = TEMP_W'(clamp_int(int'(bus.target_temp), T_MIN, T_MAX));
          rem_d    = bus.bake_cycles;
`ifdef OVEN_PREHEAT_TIMEOUT_EN
          pc_d     = '0;
`endif
        end
      end
      ST_PREHEAT: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (bus.preheated) begin
          state_d = ST_BAKE;
        end
`ifdef OVEN_PREHEAT_TIMEOUT_EN
        else if (pc_q == PC_LAST) begin
          state_d = ST_FAULT;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
`endif
      end
      ST_BAKE: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - TIME_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef OVEN_PREHEAT_TIMEOUT_EN
      ST_FAULT: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    heat_d = HEAT_OFF;
    if (state_d == ST_PREHEAT || state_d == ST_BAKE) begin
      heat_d = law_heat;
    end
  end

  assign bus.target_q  = target_q;
  assign bus.heat      = heat_q;
  assign bus.state     = 3'(state_q);
  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule
